mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Round-robin arbiter that shares the single processor memory port among four requesters (e.g. fetch, load/store, DMA, debug). It drives the 2-bit select of the external `four_one_mux` instances that steer requester address/write-data onto the port. It sequences one memory transaction at a time and returns read data plus a per-requester completion pulse. A watchdog terminates transactions the memory never acknowledges.

## Interface
- `DATA_WIDTH`, 16, width of read data path
- `TIMEOUT`, 255, max BUSY cycles awaiting `mem_ready` before forced completion (1..2^16-1)
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `req`  in  4  per-requester request; bit i = requester i
- `req_wr`  in  4  per-requester write flag, valid while `req[i]` high
- `gnt`  out  4  one-hot grant; zero when no transaction in flight
- `mux_sel`  out  2  index of granted requester; drives external addr/wdata `four_one_mux` selects
- `mem_rd`  out  1  memory read strobe
- `mem_wr`  out  1  memory write strobe
- `mem_ready`  in  1  memory acknowledge, sampled only in BUSY
- `mem_rdata`  in  DATA_WIDTH  memory read data, valid with `mem_ready`
- `done`  out  4  one-cycle completion pulse, one-hot
- `err`  out  1  high with `done` when completion was due to timeout
- `rdata`  out  DATA_WIDTH  registered read data, valid while `done` high

## Operation
- States: IDLE, BUSY, DONE. Reset -> IDLE.
- IDLE: if `req != 0`, pick winner by searching from `ptr`, `ptr+1`, ... mod 4; first set bit wins. Next edge: BUSY, `gnt` = one-hot(winner), `mux_sel` = winner, `mem_rd` = ~`req_wr[winner]`, `mem_wr` = `req_wr[winner]`, timeout counter = 0. No request: stay IDLE.
- BUSY: `gnt`, `mux_sel`, strobes held constant. Counter increments each cycle. On `mem_ready`=1: next edge -> DONE, `rdata` <= `mem_rdata` (read) or 0 (write), `err`=0. Else if counter == TIMEOUT-1: next edge -> DONE, `rdata`=0, `err`=1.
- DONE: `done[winner]`=1, `gnt`=0, strobes=0, `mux_sel` holds winner. Next edge -> IDLE, `ptr` = winner+1 mod 4, `done`/`err` clear.
- Requesters hold `req`, `req_wr`, address and write data stable from assertion until `done` seen; clear `req` at the edge ending DONE. Deasserting `req` while BUSY does not abort; the transaction completes normally.
- `ptr` updates only on completion (normal or timeout), never on idle cycles.
- `mem_ready` outside BUSY is ignored.

## Timing
- Reset values (asynchronous, immediate): state IDLE, `ptr`=0, `gnt`=0, `mux_sel`=0, `mem_rd`=`mem_wr`=0, `done`=0, `err`=0, `rdata`=0, counter=0. Reset mid-BUSY drops strobes immediately; the transaction is lost and no `done` is issued.
- All outputs registered; no combinational path from inputs to outputs.
- Zero-wait memory: `req` sampled at edge E0 -> BUSY for cycle E0..E1 -> `mem_ready` sampled at E1 -> `done` for E1..E2 -> IDLE at E2. Minimum 3 cycles per transaction; next grant can be issued at edge E3.
- N wait states add N cycles in BUSY.
- Timeout: BUSY lasts exactly TIMEOUT cycles, then DONE with `err`=1.
- `mem_ready` and timeout in the same cycle: `mem_ready` wins, so `err`=0 and data is captured.

## Test plan
- Single read, zero wait: `req`=0001, `req_wr`=0, `mem_ready`=1, `mem_rdata`=16'hBEEF -> `gnt`=0001 and `mem_rd`=1 for 1 cycle, then `done`=0001 with `rdata`=16'hBEEF, `err`=0. Afterwards `ptr`=1.
- Round-robin: `req`=1111 held (each cleared on its `done`, then reasserted), `ptr`=0 -> grant order 0,1,2,3,0; `mux_sel` sequence 0,1,2,3,0.
- Write with 3 wait states: `req`=0100, `req_wr`=0100, `mem_ready` high on 4th BUSY cycle -> `mem_wr`=1 for 4 cycles, `mux_sel`=2, then `done`=0100 and `rdata`=0.
- Timeout: TIMEOUT=8, `req`=0010, `mem_ready` held 0 -> 8 BUSY cycles, then `done`=0010, `err`=1, `rdata`=0. Next arbitration starts from `ptr`=2.
- Reset mid-BUSY: assert `reset_n`=0 in the 2nd BUSY cycle -> `gnt`, `mem_rd`, `mem_wr` go to 0 without waiting for an edge; no `done` pulse. After release with `req`=1000, the grant goes to requester 3 from `ptr`=0.
- Drop `req` during BUSY plus a late `mem_ready`: `req[1]` deasserted mid-BUSY -> the transaction still completes with `done`=0010. A `mem_ready` pulse while IDLE produces no `done` or state change.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the shared processor memory port: one transaction at a time,
// per-requester completion pulse, watchdog for memories that never acknowledge.
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [3:0]            req,
    input  logic [3:0]            req_wr,
    output logic [3:0]            gnt,
    output logic [1:0]            mux_sel,
    output logic                  mem_rd,
    output logic                  mem_wr,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [3:0]            done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] LAST_CNT = 16'(TIMEOUT - 1);

    state_t      state;
    logic [1:0]  ptr;
    logic [15:0] cnt;
    logic [1:0]  winner;

    // Search order starts at ptr; first requester found wins.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        found  = 1'b0;
        winner = ptr;
        idx    = ptr;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            ptr     <= 2'd0;
            cnt     <= 16'd0;
            gnt     <= 4'd0;
            mux_sel <= 2'd0;
            mem_rd  <= 1'b0;
            mem_wr  <= 1'b0;
            done    <= 4'd0;
            err     <= 1'b0;
            rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state   <= BUSY;
                        gnt     <= 4'(1) << winner;
                        mux_sel <= winner;
                        mem_rd  <= ~req_wr[winner];
                        mem_wr  <= req_wr[winner];
                        cnt     <= 16'd0;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 16'd1;
                    // An acknowledge in the final watchdog cycle still counts as a normal completion.
                    if (mem_ready) begin
                        state  <= DONE;
                        rdata  <= mem_wr ? '0 : mem_rdata;
                        err    <= 1'b0;
                        done   <= gnt;
                        gnt    <= 4'd0;
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                    end else if (cnt == LAST_CNT) begin
                        state  <= DONE;
                        rdata  <= '0;
                        err    <= 1'b1;
                        done   <= gnt;
                        gnt    <= 4'd0;
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ptr   <= mux_sel + 2'd1;
                    done  <= 4'd0;
                    err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, read, round-robin, wait states, timeout,
// asynchronous reset mid-transaction and request drop / stray acknowledge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [3:0]  req_wr;
    logic [3:0]  gnt;
    logic [1:0]  mux_sel;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic [3:0]  done;
    logic        err;
    logic [15:0] rdata;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(.DATA_WIDTH(16), .TIMEOUT(8)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_wr(req_wr),
        .gnt(gnt), .mux_sel(mux_sel), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .done(done), .err(err), .rdata(rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req = 4'd0; req_wr = 4'd0; mem_ready = 1'b0; mem_rdata = 16'd0;
        tick();
        checks++; if (gnt !== 4'd0) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        checks++; if (mux_sel !== 2'd0) begin failures++; $display("FAIL reset_mux_sel got=%0d exp=0", mux_sel); end
        checks++; if ({mem_rd, mem_wr} !== 2'b00) begin failures++; $display("FAIL reset_strobes got=%b exp=00", {mem_rd, mem_wr}); end
        checks++; if ({done, err} !== 5'd0) begin failures++; $display("FAIL reset_done_err got=%b exp=00000", {done, err}); end
        checks++; if (rdata !== 16'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", rdata); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        req = 4'b0001; req_wr = 4'b0000; mem_ready = 1'b1; mem_rdata = 16'hBEEF;
        tick();
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL read_gnt got=%b exp=0001", gnt); end
        checks++; if ({mem_rd, mem_wr} !== 2'b10) begin failures++; $display("FAIL read_strobes got=%b exp=10", {mem_rd, mem_wr}); end
        checks++; if (done !== 4'b0000) begin failures++; $display("FAIL read_early_done got=%b exp=0000", done); end
        tick();
        checks++; if (done !== 4'b0001) begin failures++; $display("FAIL read_done got=%b exp=0001", done); end
        checks++; if (rdata !== 16'hBEEF) begin failures++; $display("FAIL read_rdata got=%h exp=beef", rdata); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL read_err got=%b exp=0", err); end
        checks++; if ({gnt, mem_rd} !== 5'd0) begin failures++; $display("FAIL read_done_gnt got=%b exp=00000", {gnt, mem_rd}); end
        req = 4'b0000; mem_ready = 1'b0;
        tick();
        checks++; if (done !== 4'b0000) begin failures++; $display("FAIL read_done_clear got=%b exp=0000", done); end
        // ptr is now 1: with 0 and 1 both requesting, 1 must win
        req = 4'b0011; mem_ready = 1'b1; mem_rdata = 16'h1111;
        tick();
        checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL read_ptr_gnt got=%b exp=0010", gnt); end
        tick();
        req = 4'b0000; mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        req = 4'b1111; req_wr = 4'b0000; mem_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            mem_rdata = 16'hA000 + 16'(k);
            tick();
            checks++; if (gnt !== (4'(1) << exp_order[k])) begin failures++; $display("FAIL rr_gnt%0d got=%b exp=%b", k, gnt, 4'(1) << exp_order[k]); end
            checks++; if (mux_sel !== exp_order[k]) begin failures++; $display("FAIL rr_mux_sel%0d got=%0d exp=%0d", k, mux_sel, exp_order[k]); end
            tick();
            checks++; if (done !== (4'(1) << exp_order[k])) begin failures++; $display("FAIL rr_done%0d got=%b exp=%b", k, done, 4'(1) << exp_order[k]); end
            checks++; if (rdata !== 16'hA000 + 16'(k)) begin failures++; $display("FAIL rr_rdata%0d got=%h exp=%h", k, rdata, 16'hA000 + 16'(k)); end
            req[exp_order[k]] = 1'b0;
            tick();
            req[exp_order[k]] = 1'b1;
        end
        req = 4'b0000; mem_ready = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_write_wait();
        do_reset();
        req = 4'b0100; req_wr = 4'b0100; mem_ready = 1'b0; mem_rdata = 16'h1234;
        tick();
        for (int c = 1; c <= 4; c++) begin
            checks++; if ({mem_wr, mem_rd} !== 2'b10) begin failures++; $display("FAIL wr_strobes_c%0d got=%b exp=10", c, {mem_wr, mem_rd}); end
            checks++; if (mux_sel !== 2'd2) begin failures++; $display("FAIL wr_mux_sel_c%0d got=%0d exp=2", c, mux_sel); end
            checks++; if (done !== 4'b0000) begin failures++; $display("FAIL wr_early_done_c%0d got=%b exp=0000", c, done); end
            if (c == 4) mem_ready = 1'b1;
            tick();
        end
        checks++; if (done !== 4'b0100) begin failures++; $display("FAIL wr_done got=%b exp=0100", done); end
        checks++; if (rdata !== 16'h0) begin failures++; $display("FAIL wr_rdata got=%h exp=0000", rdata); end
        checks++; if (mem_wr !== 1'b0) begin failures++; $display("FAIL wr_strobe_drop got=%b exp=0", mem_wr); end
        req = 4'b0000; req_wr = 4'b0000; mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        // ptr is 3 here; requester 1 is the only one asking
        req = 4'b0010; req_wr = 4'b0000; mem_ready = 1'b0; mem_rdata = 16'hDEAD;
        tick();
        for (int c = 1; c <= 8; c++) begin
            checks++; if ({gnt, done} !== 8'b0010_0000) begin failures++; $display("FAIL to_busy_c%0d got=%b exp=00100000", c, {gnt, done}); end
            tick();
        end
        checks++; if (done !== 4'b0010) begin failures++; $display("FAIL to_done got=%b exp=0010", done); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", err); end
        checks++; if (rdata !== 16'h0) begin failures++; $display("FAIL to_rdata got=%h exp=0000", rdata); end
        req = 4'b0000;
        tick();
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL to_err_clear got=%b exp=0", err); end
        // ptr must be 2: of requesters 1 and 2, 2 wins; acknowledge arrives in the last watchdog cycle
        req = 4'b0110; mem_rdata = 16'h7777;
        tick();
        checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL to_ptr_gnt got=%b exp=0100", gnt); end
        for (int c = 1; c <= 8; c++) begin
            if (c == 8) mem_ready = 1'b1;
            tick();
        end
        checks++; if ({done, err} !== 5'b0100_0) begin failures++; $display("FAIL to_race_done_err got=%b exp=01000", {done, err}); end
        checks++; if (rdata !== 16'h7777) begin failures++; $display("FAIL to_race_rdata got=%h exp=7777", rdata); end
        req = 4'b0000; mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_busy();
        req = 4'b0001; req_wr = 4'b0000; mem_ready = 1'b0;
        tick();
        tick();
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({gnt, mem_rd, mem_wr} !== 6'd0) begin failures++; $display("FAIL rst_busy_drop got=%b exp=000000", {gnt, mem_rd, mem_wr}); end
        req = 4'b1000;
        tick();
        checks++; if (done !== 4'b0000) begin failures++; $display("FAIL rst_busy_done got=%b exp=0000", done); end
        reset_n = 1'b1;
        tick();
        checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL rst_busy_gnt got=%b exp=1000", gnt); end
        checks++; if (mux_sel !== 2'd3) begin failures++; $display("FAIL rst_busy_mux_sel got=%0d exp=3", mux_sel); end
        mem_ready = 1'b1;
        tick();
        checks++; if (done !== 4'b1000) begin failures++; $display("FAIL rst_busy_after_done got=%b exp=1000", done); end
        req = 4'b0000; mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_drop_req();
        req = 4'b0010; req_wr = 4'b0000; mem_ready = 1'b0; mem_rdata = 16'h5A5A;
        tick();
        checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL drop_gnt got=%b exp=0010", gnt); end
        req = 4'b0000;
        tick();
        tick();
        checks++; if ({gnt, mem_rd} !== 5'b0010_1) begin failures++; $display("FAIL drop_hold got=%b exp=00101", {gnt, mem_rd}); end
        mem_ready = 1'b1;
        tick();
        checks++; if (done !== 4'b0010) begin failures++; $display("FAIL drop_done got=%b exp=0010", done); end
        checks++; if (rdata !== 16'h5A5A) begin failures++; $display("FAIL drop_rdata got=%h exp=5a5a", rdata); end
        mem_ready = 1'b0;
        tick();
        mem_ready = 1'b1;
        tick();
        tick();
        checks++; if ({done, gnt, mem_rd, mem_wr} !== 10'd0) begin failures++; $display("FAIL idle_ready got=%b exp=0000000000", {done, gnt, mem_rd, mem_wr}); end
        mem_ready = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_wait();
        test_timeout();
        test_reset_mid_busy();
        test_drop_req();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
